// File: rtl/regfile_debug_port_pkg.sv
// Shared definitions for the register-file debug port.
// Holds the FSM state enumeration, the default register-file geometry
// (NREGS x WIDTH, addressed by AW bits) and the indices of the PC and LR
// registers, which a load writes last because it walks r0..r7 upward.
package regfile_debug_port_pkg;

  localparam int NREGS  = 8;
  localparam int WIDTH  = 8;
  localparam int AW     = 3;
  localparam int PC_IDX = 7;
  localparam int LR_IDX = 6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DUMP_RD  = 3'd1,
    ST_DUMP_OUT = 3'd2,
    ST_LOAD     = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_debug_port_if.sv
// Bus bundle between the debug port, the host link and the register file.
//   requests  : dump_req, load_req (host -> port)
//   status    : busy, done, cpu_stall (port -> host / CPU controller)
//   reg file  : rf_ra, rf_rd, rf_wa, rf_wd, rf_we
//   dump path : out_data, out_valid, out_ready
//   load path : in_data, in_valid, in_ready
//   debug     : dbg_state (current FSM state)
// Handshake rule for both streams: a beat transfers on a rising clock edge
// where valid and ready are both high; the producer holds its data stable
// while valid is high and ready is low, and never withdraws valid before
// the transfer happens.
// master = the debug port, slave = the surrounding host/register file.
interface regfile_debug_port_if;
  import regfile_debug_port_pkg::*;

  logic             dump_req;
  logic             load_req;
  logic             busy;
  logic             done;
  logic             cpu_stall;
  logic [AW-1:0]    rf_ra;
  logic [WIDTH-1:0] rf_rd;
  logic [AW-1:0]    rf_wa;
  logic [WIDTH-1:0] rf_wd;
  logic             rf_we;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  state_e           dbg_state;

  modport master (
    input  dump_req, load_req, rf_rd, out_ready, in_data, in_valid,
    output busy, done, cpu_stall, rf_ra, rf_wa, rf_wd, rf_we,
           out_data, out_valid, in_ready, dbg_state
  );

  modport slave (
    output dump_req, load_req, rf_rd, out_ready, in_data, in_valid,
    input  busy, done, cpu_stall, rf_ra, rf_wa, rf_wd, rf_we,
           out_data, out_valid, in_ready, dbg_state
  );

endinterface

// File: rtl/regfile_debug_port_reg_index_counter.sv
// Register index counter shared by the dump and load walks.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : force the index back to 0 (has priority)
//   inc_i         : advance the index by one
//   idx_o         : current index
//   last_o        : index is at N-1
// The index saturates at N-1 so it can never wrap back onto r0.
module reg_index_counter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] idx_o,
  output logic         last_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i && (idx_q != LAST)) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == LAST);

endmodule

// File: rtl/regfile_debug_port.sv
// Debug-side initiator for the CPU register file.
//   CLK   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : regfile_debug_port_if.master (requests, status, register-file
//           read/write ports, dump output stream, load input stream, state)
// A dump reads r0..r7 one at a time (read cycle, then a hold-until-accepted
// output cycle). A load writes r0..r7 from the input stream, one register
// per accepted beat. While not idle the CPU controller is stalled.
module regfile_debug_port
  import regfile_debug_port_pkg::*;
(
  input  logic                 CLK,
  input  logic                 reset,
  regfile_debug_port_if.master bus
);

  state_e           state_q;
  logic [WIDTH-1:0] out_data_q;
  logic [AW-1:0]    idx;
  logic             last;
  logic             idx_clr;
  logic             idx_inc;
  logic             out_hs;
  logic             in_hs;

  assign out_hs  = (state_q == ST_DUMP_OUT) && bus.out_ready;
  assign in_hs   = (state_q == ST_LOAD) && bus.in_valid;
  assign idx_clr = (state_q == ST_IDLE) || (state_q == ST_DONE);
  // The final beat does not advance the index; the FSM leaves for DONE instead.
  assign idx_inc = (out_hs || in_hs) && !last;

  reg_index_counter #(
    .N (NREGS),
    .W (AW)
  ) u_idx (
    .clk_i  (CLK),
    .rst_ni (reset),
    .clr_i  (idx_clr),
    .inc_i  (idx_inc),
    .idx_o  (idx),
    .last_o (last)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      out_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Dump has priority when both requests are present.
          if (bus.dump_req) begin
            state_q <= ST_DUMP_RD;
          end else if (bus.load_req) begin
            state_q <= ST_LOAD;
          end
        end
        ST_DUMP_RD: begin
          out_data_q <= bus.rf_rd;
          state_q    <= ST_DUMP_OUT;
        end
        ST_DUMP_OUT: begin
          if (bus.out_ready) begin
            state_q <= last ? ST_DONE : ST_DUMP_RD;
          end
        end
        ST_LOAD: begin
          if (bus.in_valid && last) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Status and stream controls decode straight from the state register, so
  // reset forces them low without waiting for a clock edge.
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.cpu_stall = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.out_valid = (state_q == ST_DUMP_OUT);
  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_data  = out_data_q;
  assign bus.rf_ra     = idx;
  assign bus.rf_wa     = idx;
  assign bus.rf_wd     = bus.in_data;
  assign bus.rf_we     = in_hs;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_regfile_debug_port.sv
module tb_regfile_debug_port;
  import regfile_debug_port_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  regfile_debug_port_if bus ();

  regfile_debug_port dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- register file attached to the port ----------------
  logic [WIDTH-1:0]    rf [NREGS];
  logic                preload = 1'b0;
  logic [AW+WIDTH-1:0] wr_log [$];

  assign bus.rf_rd = rf[bus.rf_ra];

  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= WIDTH'(8'h10 + i);
    end else if (bus.rf_we) begin
      rf[bus.rf_wa] <= bus.rf_wd;
      wr_log.push_back({bus.rf_wa, bus.rf_wd});
    end
  end

  // ---------------- reference model + scoreboard state ----------------
  logic [WIDTH-1:0] ref_regs  [NREGS];
  logic [WIDTH-1:0] last_dump [NREGS];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: out_ready always 1, 1: ready pattern 1-0-0-1 per valid cycle, 2: random
  task automatic run_dump(input int mode, input logic both_req);
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] held;
    logic stalled, rdy;
    int cyc, nbeat, nvalid, busy_cyc, done_cnt, done_cyc, first_cyc, prev_cyc;
    int bad_gap, bad_hold, bad_side, wlog0;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < NREGS; i++) exp_q.push_back(ref_regs[i]);
    stalled = 1'b0; held = '0;
    nbeat = 0; nvalid = 0; busy_cyc = 0; done_cnt = 0; done_cyc = -1;
    first_cyc = -1; prev_cyc = -1; bad_gap = 0; bad_hold = 0; bad_side = 0;
    wlog0 = wr_log.size();
    @(negedge CLK);
    bus.dump_req = 1'b1;
    bus.load_req = both_req;
    @(negedge CLK);
    bus.dump_req = 1'b0;
    bus.load_req = 1'b0;
    cyc = 1;
    check("dump_busy_rise", bus.busy, 1);
    while (bus.busy === 1'b1 && cyc < 300) begin
      busy_cyc++;
      if (bus.cpu_stall !== 1'b1) bad_side++;
      if (bus.in_ready !== 1'b0 || bus.rf_we !== 1'b0) bad_side++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stalled && (bus.out_valid !== 1'b1 || bus.out_data !== held)) bad_hold++;
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = pat[nvalid % 4];
      else rdy = 1'($urandom_range(0, 1));
      bus.out_ready = rdy;
      stalled = 1'b0;
      if (bus.out_valid === 1'b1) begin
        nvalid++;
        if (rdy) begin
          if (exp_q.size() == 0) check("dump_extra_beat", nbeat + 1, NREGS);
          else check("dump_beat", bus.out_data, exp_q.pop_front());
          if (nbeat < NREGS) last_dump[nbeat] = bus.out_data;
          if (nbeat == 0) first_cyc = cyc;
          else if (cyc - prev_cyc != 2) bad_gap++;
          prev_cyc = cyc;
          nbeat++;
        end else begin
          stalled = 1'b1;
          held    = bus.out_data;
        end
      end
      // a load request pulsed mid-dump must be dropped, not queued
      bus.load_req = both_req && (cyc == 5);
      @(negedge CLK);
      cyc++;
    end
    bus.out_ready = 1'b0;
    bus.load_req  = 1'b0;
    check("dump_timeout", (cyc < 300), 1);
    check("dump_beat_count", nbeat, NREGS);
    check("dump_done_count", done_cnt, 1);
    check("dump_done_after_last", done_cyc, prev_cyc + 1);
    check("dump_data_held", bad_hold, 0);
    check("dump_side_signals", bad_side, 0);
    check("dump_no_writes", wr_log.size(), wlog0);
    if (mode == 0) begin
      check("dump_first_latency", first_cyc, 2);
      check("dump_beat_spacing", bad_gap, 0);
      check("dump_busy_cycles", busy_cyc, 2 * NREGS + 1);
    end
    @(negedge CLK);
    check("dump_idle_after", bus.busy, 0);
  endtask

  // mode 0: in_valid always 1, 1: random gaps, 2: fixed gap pattern
  // abort_at > 0: assert reset once that many writes have landed
  task automatic run_load(input int mode, input logic rand_data, input int abort_at);
    logic [WIDTH-1:0] vals [NREGS];
    logic v;
    int cyc, nw, done_cnt, done_cyc, bad_stall, wlog0;
    bit gp [12];
    gp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < NREGS; i++)
      vals[i] = rand_data ? WIDTH'($urandom_range(0, 255)) : WIDTH'(8'hA0 + i);
    nw = 0; done_cnt = 0; done_cyc = -1; bad_stall = 0;
    wlog0 = wr_log.size();
    @(negedge CLK);
    bus.load_req = 1'b1;
    @(negedge CLK);
    bus.load_req = 1'b0;
    cyc = 1;
    check("load_busy_rise", bus.busy, 1);
    while (bus.busy === 1'b1 && cyc < 300) begin
      if (bus.cpu_stall !== 1'b1) bad_stall++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.in_ready === 1'b1) begin
        if (abort_at > 0 && nw == abort_at) v = 1'b1;
        else if (mode == 0) v = 1'b1;
        else if (mode == 2) v = gp[(cyc - 1) % 12];
        else v = ($urandom_range(0, 2) != 0);
        bus.in_valid = v;
        bus.in_data  = v ? vals[nw] : WIDTH'($urandom_range(0, 255));
        #1;
        check("load_we", bus.rf_we, v);
        check("load_wa", bus.rf_wa, nw);
        if (v) check("load_wd", bus.rf_wd, vals[nw]);
        if (abort_at > 0 && nw == abort_at) begin
          reset = 1'b0;
          #1;
          check("abort_we_drop", bus.rf_we, 0);
          check("abort_busy_drop", bus.busy, 0);
          check("abort_stall_drop", bus.cpu_stall, 0);
          check("abort_in_ready_drop", bus.in_ready, 0);
          break;
        end
        if (v) begin
          ref_regs[nw] = vals[nw];
          nw++;
        end
      end else begin
        bus.in_valid = 1'b0;
        #1;
        check("load_we_outside_load", bus.rf_we, 0);
      end
      @(negedge CLK);
      cyc++;
    end
    bus.in_valid = 1'b0;
    if (abort_at > 0) begin
      @(negedge CLK);
      check("abort_done_in_reset", bus.done, 0);
      reset = 1'b1;
      repeat (3) begin
        @(negedge CLK);
        if (bus.done === 1'b1) done_cnt++;
        check("abort_stays_idle", bus.busy, 0);
      end
      check("abort_no_done", done_cnt, 0);
      check("abort_write_count", wr_log.size() - wlog0, abort_at);
      check("abort_state", bus.dbg_state, ST_IDLE);
    end else begin
      check("load_timeout", (cyc < 300), 1);
      check("load_write_count", nw, NREGS);
      check("load_log_count", wr_log.size() - wlog0, NREGS);
      check("load_done_count", done_cnt, 1);
      check("load_done_last", done_cyc, cyc - 1);
      check("load_stall_held", bad_stall, 0);
      if (mode == 0) check("load_total_cycles", cyc, NREGS + 2);
      for (int i = 0; i < NREGS; i++)
        if (wlog0 + i < wr_log.size())
          check("load_write_order", wr_log[wlog0 + i], {AW'(i), vals[i]});
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bus.dump_req  = 1'b0;
    bus.load_req  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    preload       = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge CLK);
    bus.dump_req = 1'b1;
    @(negedge CLK);
    check("rst_busy", bus.busy, 0);
    check("rst_cpu_stall", bus.cpu_stall, 0);
    check("rst_done", bus.done, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_rf_ra", bus.rf_ra, 0);
    check("rst_state", bus.dbg_state, ST_IDLE);
    bus.dump_req = 1'b0;
    preload = 1'b0;
    for (int i = 0; i < NREGS; i++) ref_regs[i] = WIDTH'(8'h10 + i);
    reset = 1'b1;
    @(negedge CLK);
    check("idle_after_reset", bus.busy, 0);

    run_dump(0, 1'b0);
    run_load(0, 1'b0, 0);
    run_dump(0, 1'b0);
    check("pc_after_load", last_dump[PC_IDX], 8'hA7);
    check("lr_after_load", last_dump[LR_IDX], 8'hA6);
    run_dump(1, 1'b0);
    run_dump(2, 1'b1);
    run_load(1, 1'b1, 3);
    run_dump(2, 1'b0);
    run_load(2, 1'b1, 0);
    run_dump(2, 1'b0);
    repeat (4) begin
      run_load(1, 1'b1, 0);
      run_dump(2, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
